dm_access_ctrl: RTL and testbench

//  Sequences M-stage loads/stores onto a variable-latency data-memory bus (req/gnt/rvalid).

---
 rtl/dm_ctrl_pkg.sv | 24 ++
 rtl/dm_access_ctrl_if.sv | 21 ++
 rtl/dm_lane_align.sv | 47 ++++
 rtl/dm_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared width codes, FSM state encoding and defaults for the data-memory access controller.
package dm_ctrl_pkg;

  localparam logic [2:0] W_WORD = 3'd0;
  localparam logic [2:0] W_HALF = 3'd1;
  localparam logic [2:0] W_BYTE = 3'd2;

  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Unknown width codes behave as word accesses, so they must be word aligned.
  function automatic logic misaligned(input logic [2:0] width, input logic [1:0] off);
    if (width == W_BYTE) return 1'b0;
    if (width == W_HALF) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Data-memory bus: request/grant handshake with a separate read-data valid.
interface dm_access_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic: store byte enables/replication and load lane select/extension.
module dm_lane_align
  import dm_ctrl_pkg::*;
(
  input  logic [2:0]  st_width,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_width,
  input  logic [1:0]  ld_off,
  input  logic        ld_sign,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    if (st_width == W_HALF) begin
      st_be    = st_off[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{st_data[15:0]}};
    end else if (st_width == W_BYTE) begin
      st_be    = 4'b0001 << st_off;
      st_wdata = {4{st_data[7:0]}};
    end
  end

  always_comb begin
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    unique case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_data = ld_word;
    if (ld_width == W_HALF)
      ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
    else if (ld_width == W_BYTE)
      ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// M-stage load/store sequencer for a req/gnt/rvalid data-memory bus with watchdog abort.
// Optional misalignment trapping is enabled by defining DM_ALIGN_CHECK_EN.
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m_valid,
  input  logic                    m_we,
  input  logic [2:0]              m_width,
  input  logic                    m_sign,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  output logic                    stall,
  output logic                    done,
  output logic [31:0]             rdata,
  output logic                    bus_err,
  output logic                    addr_err,
  dm_access_ctrl_if.master        dm
);

  state_t      state_q, state_d;
  logic        we_q, we_d, sign_q, sign_d;
  logic [2:0]  width_q, width_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        bus_err_q, bus_err_d, addr_err_q, addr_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        timeout;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  dm_lane_align u_align (
    .st_width (m_width),
    .st_off   (m_addr[1:0]),
    .st_data  (m_wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_width (width_q),
    .ld_off   (addr_q[1:0]),
    .ld_sign  (sign_q),
    .ld_word  (dm.dm_rdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    width_d    = width_q;
    sign_d     = sign_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    bus_err_d  = bus_err_q;
    addr_err_d = addr_err_q;
    cnt_d      = cnt_q;
    timeout    = (cnt_q + CNT_W'(1)) == CNT_W'(MAX_WAIT);
    unique case (state_q)
      S_IDLE: begin
        if (m_valid) begin
          we_d       = m_we;
          width_d    = m_width;
          sign_d     = m_sign;
          addr_d     = m_addr;
          be_d       = st_be;
          wdata_d    = st_wdata;
          rdata_d    = '0;
          bus_err_d  = 1'b0;
          addr_err_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_REQ;
`ifdef DM_ALIGN_CHECK_EN
          if (misaligned(m_width, m_addr[1:0])) begin
            state_d    = S_RESP;
            addr_err_d = 1'b1;
          end
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A granted store is complete; a granted load still owes its data beat.
        if (dm.dm_gnt && we_q) begin
          state_d = S_RESP;
        end else if (timeout) begin
          state_d   = S_RESP;
          bus_err_d = 1'b1;
        end else if (dm.dm_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dm.dm_rvalid) begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end else if (timeout) begin
          state_d   = S_RESP;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      width_q    <= W_WORD;
      sign_q     <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      width_q    <= width_d;
      sign_q     <= sign_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      addr_err_q <= addr_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign done        = (state_q == S_RESP);
  assign stall       = m_valid && !done;
  assign rdata       = done ? rdata_q : 32'h0;
  assign bus_err     = done && bus_err_q;
`ifdef DM_ALIGN_CHECK_EN
  assign addr_err    = done && addr_err_q;
`else
  assign addr_err    = 1'b0;
`endif
  assign dm.dm_req   = (state_q == S_REQ);
  assign dm.dm_we    = (state_q == S_REQ) && we_q;
  assign dm.dm_addr  = {addr_q[31:2], 2'b00};
  assign dm.dm_be    = be_q;
  assign dm.dm_wdata = wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a scoreboard of expected completions.
module tb_dm_access_ctrl;
  import dm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_we, m_sign;
  logic [2:0]  m_width;
  logic [31:0] m_addr, m_wdata;
  logic        stall, done, bus_err, addr_err;
  logic [31:0] rdata;

  dm_access_ctrl_if dm_if ();

  dm_access_ctrl #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .m_valid  (m_valid),
    .m_we     (m_we),
    .m_width  (m_width),
    .m_sign   (m_sign),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .stall    (stall),
    .done     (done),
    .rdata    (rdata),
    .bus_err  (bus_err),
    .addr_err (addr_err),
    .dm       (dm_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        bus_err;
    logic        addr_err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic we, input logic [2:0] w, input logic s,
                                           input logic [31:0] a, input logic [31:0] word);
    logic [31:0] sh;
    if (we) return 32'h0;
    if (w == W_HALF) begin
      sh = word >> (a[1] ? 16 : 0);
      return s ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    end
    if (w == W_BYTE) begin
      sh = word >> (8 * int'(a[1:0]));
      return s ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    end
    return word;
  endfunction

  // One access: drive at cycle 0, pulse gnt/rvalid at given cycle indices, score on done.
  task automatic access(input string tag, input logic we, input logic [2:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                        input int gnt_at, input int rv_at, input logic exp_berr,
                        input logic exp_aerr, input int exp_lat, input logic exp_req,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    exp_t e, got_e;
    logic seen_req, got, stall_ok, req_we;
    logic [3:0] req_be;
    logic [31:0] req_wd, req_addr;
    e.rdata    = (exp_berr || exp_aerr) ? 32'h0 : model_rd(we, w, s, a, rword);
    e.bus_err  = exp_berr;
    e.addr_err = exp_aerr;
    e.lat      = exp_lat;
    sb.push_back(e);
    seen_req = 1'b0; got = 1'b0; stall_ok = 1'b1;
    req_we = 1'b0; req_be = '0; req_wd = '0; req_addr = '0;
    @(negedge clk);
    m_valid = 1'b1; m_we = we; m_width = w; m_sign = s; m_addr = a; m_wdata = wd;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 1) begin
        m_addr = ~a; m_wdata = ~wd; m_we = ~we; m_sign = ~s;
      end
      dm_if.dm_gnt    = (cyc == gnt_at);
      dm_if.dm_rvalid = (cyc == rv_at);
      dm_if.dm_rdata  = (cyc == rv_at) ? rword : 32'h5A5A_A5A5;
      #1;
      if (done) begin
        got = 1'b1;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          got_e = sb.pop_front();
          check({tag, "_latency"}, 32'(cyc), 32'(got_e.lat));
          check({tag, "_rdata"}, rdata, got_e.rdata);
          check({tag, "_bus_err"}, 32'(bus_err), 32'(got_e.bus_err));
          check({tag, "_addr_err"}, 32'(addr_err), 32'(got_e.addr_err));
        end
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        break;
      end
      if (!stall) stall_ok = 1'b0;
      if (dm_if.dm_req && !seen_req) begin
        seen_req = 1'b1; req_be = dm_if.dm_be; req_wd = dm_if.dm_wdata;
        req_addr = dm_if.dm_addr; req_we = dm_if.dm_we;
      end
    end
    m_valid = 1'b0;
    dm_if.dm_gnt = 1'b0; dm_if.dm_rvalid = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_stall_until_done"}, 32'(stall_ok), 32'd1);
    check({tag, "_req_issued"}, 32'(seen_req), 32'(exp_req));
    if (exp_req && seen_req) begin
      check({tag, "_dm_be"}, 32'(req_be), 32'(exp_be));
      check({tag, "_dm_addr"}, req_addr, {a[31:2], 2'b00});
      check({tag, "_dm_we"}, 32'(req_we), 32'(we));
      if (we) check({tag, "_dm_wdata"}, req_wd, exp_wd);
    end
  endtask

  initial begin
    reset = 1'b0; m_valid = 1'b0; m_we = 1'b0; m_width = W_WORD; m_sign = 1'b0;
    m_addr = '0; m_wdata = '0;
    dm_if.dm_gnt = 1'b0; dm_if.dm_rvalid = 1'b0; dm_if.dm_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(dm_if.dm_req), 32'd0);
    check("rst_stall_idle", 32'(stall), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_be", 32'(dm_if.dm_be), 32'd0);
    m_valid = 1'b1;
    #1;
    check("rst_stall_follows_valid", 32'(stall), 32'd1);
    @(negedge clk);
    m_valid = 1'b0; reset = 1'b1;

    // Stray read data while idle must not complete anything.
    @(negedge clk);
    dm_if.dm_rvalid = 1'b1; dm_if.dm_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dm_if.dm_rvalid = 1'b0;
    #1;
    check("stray_rvalid_done", 32'(done), 32'd0);
    check("stray_rvalid_req", 32'(dm_if.dm_req), 32'd0);

    access("sw", 1'b1, W_WORD, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1, -1,
           1'b0, 1'b0, 2, 1'b1, 4'b1111, 32'h1234_5678);
    access("lb", 1'b0, W_BYTE, 1'b1, 32'h13, 32'h0, 32'h80FF_0000, 1, 3,
           1'b0, 1'b0, 4, 1'b1, 4'b1000, 32'h0);
    access("lhu", 1'b0, W_HALF, 1'b0, 32'h12, 32'h0, 32'hBEEF_1234, 1, 2,
           1'b0, 1'b0, 3, 1'b1, 4'b1100, 32'h0);
    access("sb", 1'b1, W_BYTE, 1'b0, 32'h21, 32'h0000_00AB, 32'h0, 3, -1,
           1'b0, 1'b0, 4, 1'b1, 4'b0010, 32'hABAB_ABAB);
    access("sh", 1'b1, W_HALF, 1'b0, 32'h16, 32'h0000_BEEF, 32'h0, 1, -1,
           1'b0, 1'b0, 2, 1'b1, 4'b1100, 32'hBEEF_BEEF);
    access("lh", 1'b0, W_HALF, 1'b1, 32'h10, 32'h0, 32'h1234_8001, 1, 2,
           1'b0, 1'b0, 3, 1'b1, 4'b0011, 32'h0);
    access("lbu", 1'b0, W_BYTE, 1'b0, 32'h11, 32'h0, 32'h0000_F700, 2, 4,
           1'b0, 1'b0, 5, 1'b1, 4'b0010, 32'h0);

    // Load granted but never answered: watchdog abort after 15 bus cycles.
    access("ld_timeout", 1'b0, W_WORD, 1'b0, 32'h30, 32'h0, 32'h1111_2222, 1, -1,
           1'b1, 1'b0, 16, 1'b1, 4'b1111, 32'h0);
    @(negedge clk);
    dm_if.dm_rvalid = 1'b1; dm_if.dm_rdata = 32'hDEAD_0001;
    #1;
    check("late_rvalid_done", 32'(done), 32'd0);
    @(negedge clk);
    dm_if.dm_rvalid = 1'b0;
    #1;
    check("late_rvalid_done2", 32'(done), 32'd0);
    check("late_rvalid_req", 32'(dm_if.dm_req), 32'd0);

    access("st_timeout", 1'b1, W_WORD, 1'b0, 32'h34, 32'h7777_8888, 32'h0, -1, -1,
           1'b1, 1'b0, 16, 1'b1, 4'b1111, 32'h7777_8888);
    // Data arriving in the same cycle as the timeout takes priority.
    access("rv_vs_timeout", 1'b0, W_WORD, 1'b0, 32'h40, 32'h0, 32'h0BAD_F00D, 1, 15,
           1'b0, 1'b0, 16, 1'b1, 4'b1111, 32'h0);

`ifdef DM_ALIGN_CHECK_EN
    access("lw_misalign", 1'b0, W_WORD, 1'b0, 32'h02, 32'h0, 32'hCAFE_F00D, 1, 2,
           1'b0, 1'b1, 1, 1'b0, 4'b1111, 32'h0);
`else
    access("lw_misalign", 1'b0, W_WORD, 1'b0, 32'h02, 32'h0, 32'hCAFE_F00D, 1, 2,
           1'b0, 1'b0, 3, 1'b1, 4'b1111, 32'h0);
`endif

    // Reset asserted while a load is still requesting.
    @(negedge clk);
    m_valid = 1'b1; m_we = 1'b0; m_width = W_WORD; m_sign = 1'b0; m_addr = 32'h50;
    @(negedge clk);
    #1;
    check("midrst_req_before", 32'(dm_if.dm_req), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_req_dropped", 32'(dm_if.dm_req), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dm_if.dm_rvalid = 1'b1; dm_if.dm_rdata = 32'h1234_0000;
    @(negedge clk);
    dm_if.dm_rvalid = 1'b0;
    #1;
    check("midrst_rvalid_no_done", 32'(done), 32'd0);
    check("midrst_idle_no_req", 32'(dm_if.dm_req), 32'd0);

    access("sw_after_rst", 1'b1, W_WORD, 1'b0, 32'h60, 32'hA5A5_0F0F, 32'h0, 1, -1,
           1'b0, 1'b0, 2, 1'b1, 4'b1111, 32'hA5A5_0F0F);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
